// File: rtl/mux_sel_sequencer.sv
// Select sequencer for a 4:1 bit mux: steps `s` on a debounced press or auto tick, then shifts `y` into `led`.
// Build option SEQ_SHOW_SEL_EN: led[15:14] mirror `s` and the capture history shrinks to 14 bits.
module mux_sel_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned AUTO_PERIOD     = 5000000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_raw,
   input  logic        auto_sw,
   input  logic        y,
   output logic [1:0]  s,
   output logic [15:0] led,
   output logic        sel_valid
);

`ifdef SEQ_SHOW_SEL_EN
   localparam int HIST_W = 14;
`else
   localparam int HIST_W = 16;
`endif

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

   state_t             state_q, state_d;
   logic               btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
   logic               auto_meta_q, auto_meta_d, auto_sync_q, auto_sync_d;
   logic               btn_stable_q, btn_stable_d;
   logic               press_q, press_d;
   logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
   logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [1:0]         s_q, s_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic               sel_valid_q, sel_valid_d;
   logic               tick, step;

   // NOTE: every signal assigned in always_comb gets a default on entry, otherwise a latch is inferred.
   always_comb begin
      btn_meta_d   = btn_raw;
      btn_sync_d   = btn_meta_q;
      auto_meta_d  = auto_sw;
      auto_sync_d  = auto_meta_q;
      btn_stable_d = btn_stable_q;
      db_cnt_d     = '0;
      press_d      = 1'b0;
      if (btn_sync_q != btn_stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_stable_d = btn_sync_q;
            press_d      = btn_sync_q;  // only the 0->1 acceptance is an event
         end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
         end
      end
      if (!auto_sync_q || tick_cnt_q == TICK_LAST) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
   end

   assign tick = auto_sync_q && (tick_cnt_q == TICK_LAST);
   assign step = auto_sync_q ? tick : press_q;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; steps arriving outside IDLE are simply dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (step) state_d = ST_SETTLE;
         ST_SETTLE:  state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      s_d         = s_q;
      hist_d      = hist_q;
      sel_valid_d = (state_d == ST_IDLE);
      if (state_q == ST_IDLE && step) s_d = s_q + 2'd1;
      if (state_q == ST_CAPTURE)      hist_d = {hist_q[HIST_W-2:0], y};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta_q   <= 1'b0;
         btn_sync_q   <= 1'b0;
         auto_meta_q  <= 1'b0;
         auto_sync_q  <= 1'b0;
         btn_stable_q <= 1'b0;
         press_q      <= 1'b0;
         db_cnt_q     <= '0;
         tick_cnt_q   <= '0;
         s_q          <= 2'd0;
         hist_q       <= '0;
         sel_valid_q  <= 1'b1;
      end else begin
         btn_meta_q   <= btn_meta_d;
         btn_sync_q   <= btn_sync_d;
         auto_meta_q  <= auto_meta_d;
         auto_sync_q  <= auto_sync_d;
         btn_stable_q <= btn_stable_d;
         press_q      <= press_d;
         db_cnt_q     <= db_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         s_q          <= s_d;
         hist_q       <= hist_d;
         sel_valid_q  <= sel_valid_d;
      end
   end

   assign s         = s_q;
   assign sel_valid = sel_valid_q;
`ifdef SEQ_SHOW_SEL_EN
   assign led = {s_q, hist_q};
`else
   assign led = hist_q;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8 and y = s[0] as the mux model.
// Expected led values follow the SEQ_SHOW_SEL_EN build option when it is defined.
module tb_mux_sel_sequencer;

   logic        clk = 1'b0;
   logic        rst, btn_raw, auto_sw, y;
   logic [1:0]  s;
   logic [15:0] led;
   logic        sel_valid;

   int vectors     = 0;
   int miscompares = 0;
   int ncyc        = 0;
   int at, last_at;

   // History after each of eight consecutive steps from reset (y = 1,0,1,0,... newest in bit 0).
   logic [15:0] step_hist [0:8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h000A,
                                    16'h0015, 16'h002A, 16'h0055, 16'h00AA};

   mux_sel_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .AUTO_PERIOD    (8),
      .CNT_W          (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .auto_sw  (auto_sw),
      .y        (y),
      .s        (s),
      .led      (led),
      .sel_valid(sel_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc++;

   // Downstream 4:1 mux with inputs wired so y is high for s = 1 and 3.
   assign y = (s == 2'd1) || (s == 2'd3);

   function automatic logic [15:0] exp_led(input logic [1:0] sv, input logic [15:0] h);
`ifdef SEQ_SHOW_SEL_EN
      return {sv, h[13:0]};
`else
      return h;
`endif
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic btn);
      @(negedge clk);
      rst     = 1'b1;
      btn_raw = btn;
      auto_sw = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_s", 16'(s), 16'h0000);
      check("rst_led", led, 16'h0000);
      check("rst_sel_valid", 16'(sel_valid), 16'h0001);
      rst = 1'b0;
   endtask

   task automatic wait_s_change(input string tag, input int budget, output int t);
      logic [1:0] prev;
      int         n;
      prev = s;
      n    = 0;
      while (s === prev && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_seen"}, 16'(s !== prev), 16'h0001);
      t = ncyc;
   endtask

   // Waits for one step, then checks the SETTLE/CAPTURE window and the captured history.
   task automatic step_obs(input string tag, input logic [1:0] exp_s, input logic [15:0] prev_h,
                           input logic [15:0] new_h, input int budget, output int t);
      wait_s_change(tag, budget, t);
      check({tag, "_s"}, 16'(s), 16'(exp_s));
      check({tag, "_sel0"}, 16'(sel_valid), 16'h0000);
      check({tag, "_led_hold0"}, led, exp_led(exp_s, prev_h));
      @(negedge clk);
      check({tag, "_sel1"}, 16'(sel_valid), 16'h0000);
      check({tag, "_led_hold1"}, led, exp_led(exp_s, prev_h));
      @(negedge clk);
      check({tag, "_sel_back"}, 16'(sel_valid), 16'h0001);
      check({tag, "_led_cap"}, led, exp_led(exp_s, new_h));
   endtask

   task automatic clean_press(input string tag, input logic [1:0] exp_s, input logic [15:0] prev_h,
                              input logic [15:0] new_h);
      int t;
      btn_raw = 1'b1;
      step_obs(tag, exp_s, prev_h, new_h, 12, t);
      btn_raw = 1'b0;
      idle(10);
   endtask

   initial begin
      rst     = 1'b1;
      btn_raw = 1'b1;
      auto_sw = 1'b0;

      // Reset with the button held: the press appears only after sync + debounce.
      do_reset(1'b1);
      idle(5);
      check("early_no_press", 16'(s), 16'h0000);
      check("early_sel_valid", 16'(sel_valid), 16'h0001);
      step_obs("rst_press", 2'd1, 16'h0000, 16'h0001, 6, at);
      btn_raw = 1'b0;
      idle(10);
      check("release_no_step", 16'(s), 16'h0001);

      // Bounce rejection: 2-cycle toggles never survive the 4-cycle debounce.
      do_reset(1'b0);
      for (int i = 0; i < 20; i++) begin
         btn_raw = ((i / 2) % 2) == 0;
         @(negedge clk);
      end
      check("bounce_reject", 16'(s), 16'h0000);
      btn_raw = 1'b1;
      step_obs("bounce_press", 2'd1, 16'h0000, 16'h0001, 12, at);
      idle(7);
      btn_raw = 1'b0;
      idle(10);
      check("bounce_one_step", 16'(s), 16'h0001);
      check("bounce_led", led, exp_led(2'd1, 16'h0001));

      // Wrap and history: four clean presses.
      do_reset(1'b0);
      clean_press("wrap1", 2'd1, step_hist[0], step_hist[1]);
      clean_press("wrap2", 2'd2, step_hist[1], step_hist[2]);
      clean_press("wrap3", 2'd3, step_hist[2], step_hist[3]);
      clean_press("wrap0", 2'd0, step_hist[3], step_hist[4]);
      check("wrap_final_led", led, exp_led(2'd0, 16'h000A));

      // Auto mode: one step every 8 cycles; a button press in the middle is ignored.
      do_reset(1'b0);
      auto_sw = 1'b1;
      last_at = 0;
      for (int k = 1; k <= 8; k++) begin
         step_obs("auto", 2'(k % 4), step_hist[k-1], step_hist[k], 12, at);
         if (k >= 2) check("auto_period", 16'(at - last_at), 16'd8);
         last_at = at;
         if (k == 3) btn_raw = 1'b1;
         if (k == 4) btn_raw = 1'b0;
      end
      auto_sw = 1'b0;
      idle(16);
      check("auto_end_s", 16'(s), 16'h0000);
      check("auto_end_led", led, exp_led(2'd0, 16'h00AA));
      check("auto_end_sel", 16'(sel_valid), 16'h0001);

      // Dropped step: tick at posedge 10, then a press pulse in SETTLE after the mode drops to manual.
      do_reset(1'b0);
      auto_sw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 4)  btn_raw = 1'b1;
         if (i == 8)  auto_sw = 1'b0;
         if (i == 9)  check("drop_before_tick", 16'(s), 16'h0000);
         if (i == 10) check("drop_tick_step", 16'(s), 16'h0001);
         if (i == 14) btn_raw = 1'b0;
      end
      idle(6);
      check("drop_one_inc", 16'(s), 16'h0001);
      check("drop_led", led, exp_led(2'd1, 16'h0001));

      // Reset asserted while in CAPTURE wins over the capture.
      btn_raw = 1'b1;
      wait_s_change("midop", 12, at);
      check("midop_s", 16'(s), 16'h0002);
      @(negedge clk);
      check("midop_in_capture", 16'(sel_valid), 16'h0000);
      rst     = 1'b1;
      btn_raw = 1'b0;
      @(negedge clk);
      check("midop_rst_s", 16'(s), 16'h0000);
      check("midop_rst_led", led, 16'h0000);
      check("midop_rst_sel", 16'(sel_valid), 16'h0001);
      rst = 1'b0;
      idle(12);
      check("midop_no_capture", led, 16'h0000);
      check("midop_s_idle", 16'(s), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no completion expected finish");
      $fatal(1, "watchdog");
   end

endmodule
